axi_lite_bram_slave: RTL and testbench

//  AXI4-Lite responder (slave) bridging one CPU memory port (imem or dmem) to one port of a

---
 rtl/axi_lite_bram_slave.sv | 158 +++++++++++++++
 tb/tb_axi_lite_bram_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave bridging one CPU memory port onto one port of a byte-writable, 1-cycle-latency RAM.
// Optional AXI_BRAM_SLVERR_EN: out-of-range addresses answer SLVERR without touching the RAM.
module axi_lite_bram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           axi_awaddr,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [31:0]           axi_araddr,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-3:0] bram_addr,
    output logic [31:0]           bram_wrdata,
    input  logic [31:0]           bram_rddata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_e;
    typedef enum logic {PRIO_WR, PRIO_RD} prio_e;

    state_e      state_q, state_d;
    prio_e       prio_q, prio_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_err_q, rd_err_d;

    logic wr_elig, rd_elig, grant_wr, grant_rd, aw_err, ar_err;

`ifdef AXI_BRAM_SLVERR_EN
    function automatic logic out_of_range(input logic [31:0] addr);
        return (|addr[31:ADDR_WIDTH]) || (32'(addr[ADDR_WIDTH-1:0]) >= 32'(MEM_BYTES));
    endfunction
    assign aw_err = out_of_range(axi_awaddr);
    assign ar_err = out_of_range(axi_araddr);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Grants are only ever issued from IDLE, so a pending response blocks new traffic.
    always_comb begin
        wr_elig  = !reset && (state_q == IDLE) && axi_awvalid && axi_wvalid;
        rd_elig  = !reset && (state_q == IDLE) && axi_arvalid;
        grant_wr = wr_elig && (!rd_elig || (prio_q == PRIO_WR));
        grant_rd = rd_elig && !grant_wr;
    end

    assign axi_awready = grant_wr;
    assign axi_wready  = grant_wr;
    assign axi_arready = grant_rd;
    assign bram_en     = (grant_wr && !aw_err) || (grant_rd && !ar_err);
    assign bram_we     = (grant_wr && !aw_err) ? axi_wstrb : 4'b0000;
    assign bram_addr   = grant_wr ? axi_awaddr[ADDR_WIDTH-1:2] : axi_araddr[ADDR_WIDTH-1:2];
    assign bram_wrdata = axi_wdata;

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rresp  = rresp_q;
    assign axi_rdata  = rdata_q;

    // NOTE: every _d starts from its _q so no path through the case leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rd_err_d = rd_err_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d  = WR_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
                    prio_d   = PRIO_RD;
                end else if (grant_rd) begin
                    state_d  = RD_WAIT;
                    rd_err_d = ar_err;
                    prio_d   = PRIO_WR;
                end
            end
            WR_RESP: begin
                if (axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                rdata_d  = rd_err_q ? 32'h0 : bram_rddata;
                rresp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its _d.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= PRIO_WR;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'h0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Protection bits, sub-word offsets and (without the range check) upper address bits are don't-care.
    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[31:ADDR_WIDTH], axi_awaddr[1:0],
                         axi_araddr[31:ADDR_WIDTH], axi_araddr[1:0], (MEM_BYTES > 0)};

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Self-checking bench for axi_lite_bram_slave: directed protocol steps plus randomized traffic
// checked against a word-array memory model; build with AXI_BRAM_SLVERR_EN to cover the range check.
module tb_axi_lite_bram_slave;

    localparam int AW = 16;
`ifdef AXI_BRAM_SLVERR_EN
    localparam int MEM_TB = 32'h1000;
    localparam bit SLV_EN = 1'b1;
`else
    localparam int MEM_TB = 65536;
    localparam bit SLV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata, bram_wrdata, bram_rddata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, bram_en;
    logic [3:0]  axi_wstrb, bram_we;
    logic [1:0]  axi_bresp, axi_rresp;
    logic [AW-3:0] bram_addr;

    int errors = 0;
    int checks = 0;
    int en_count = 0;

    bit [31:0] ram       [0:(1<<(AW-2))-1];
    bit [31:0] model_mem [0:(1<<(AW-2))-1];

    axi_lite_bram_slave #(.ADDR_WIDTH(AW), .MEM_BYTES(MEM_TB)) dut (
        .clk(clk), .reset(reset),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
    );

    always #5 clk = ~clk;

    // Byte-writable RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            en_count <= en_count + 1;
            bram_rddata <= ram[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) ram[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return SLV_EN && ((a >= (32'h1 << AW)) || ((a % (32'h1 << AW)) >= 32'(MEM_TB)));
    endfunction

    function automatic logic [31:0] exp_resp(input logic [31:0] a);
        return is_err(a) ? 32'h2 : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!is_err(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[(a % (32'h1 << AW)) / 4][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return is_err(a) ? 32'h0 : model_mem[(a % (32'h1 << AW)) / 4];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the requested handshake, then steps past the accepting edge.
    task automatic wait_grant(input bit is_rd, input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = is_rd ? axi_arready : (axi_awready && axi_wready);
            if (!got) next_cycle();
        end
        chk(tag, 32'(got), 32'd1);
        next_cycle();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdelay);
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        wait_grant(1'b0, "wr_grant");
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        chk("bvalid_n1", 32'(axi_bvalid), 32'd1);
        for (int i = 0; i < bdelay; i++) begin
            next_cycle();
            chk("bvalid_hold", 32'(axi_bvalid), 32'd1);
        end
        axi_bready = 1'b1;
        @(negedge clk);
        chk("bresp", 32'(axi_bresp), exp_resp(a));
        next_cycle();
        axi_bready = 1'b0;
        chk("bvalid_drop", 32'(axi_bvalid), 32'd0);
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdelay);
        logic [31:0] exp_d;
        exp_d = model_read(a);
        axi_araddr = a;
        axi_arvalid = 1'b1;
        wait_grant(1'b1, "rd_grant");
        axi_arvalid = 1'b0;
        chk("rvalid_n1", 32'(axi_rvalid), 32'd0);
        next_cycle();
        chk("rvalid_n2", 32'(axi_rvalid), 32'd1);
        chk("rdata", axi_rdata, exp_d);
        chk("rresp", 32'(axi_rresp), exp_resp(a));
        for (int i = 0; i < rdelay; i++) begin
            next_cycle();
            chk("rvalid_hold", 32'(axi_rvalid), 32'd1);
            chk("rdata_hold", axi_rdata, exp_d);
        end
        axi_rready = 1'b1;
        next_cycle();
        axi_rready = 1'b0;
        chk("rvalid_drop", 32'(axi_rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_d;
        int          en_before;
        reset = 1'b1;
        axi_awaddr = 32'h0; axi_awprot = 3'h0; axi_wdata = 32'h0; axi_wstrb = 4'h0;
        axi_araddr = 32'h0; axi_arprot = 3'h0; axi_bready = 1'b0; axi_rready = 1'b0;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;

        // Reset: readies and RAM enable stay low even with every valid asserted.
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_awready", 32'(axi_awready), 32'd0);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rst_rdata", axi_rdata, 32'h0);
        chk("rst_resp", {28'h0, axi_bresp, axi_rresp}, 32'h0);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        next_cycle();
        reset = 1'b0;

        // Full-word write/readback, then a partial-strobe overwrite.
        axi_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(32'h0000_0010, 0);
        chk("t1_model", model_read(32'h10), 32'hDEAD_BEEF);
        axi_write(32'h0000_0010, 32'h1122_3344, 4'b0101, 1);
        axi_read(32'h0000_0010, 2);
        chk("t2_model", model_read(32'h10), 32'hDE22_BE44);

        // Write and read contending twice in a row: write wins, then read.
        axi_awaddr = 32'h20; axi_wdata = 32'hCAFE_0001; axi_wstrb = 4'hF; axi_araddr = 32'h10;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1; axi_bready = 1'b1;
        @(negedge clk);
        chk("t3_first_wr", {30'h0, axi_awready, axi_arready}, 32'h2);
        next_cycle();
        model_write(32'h20, 32'hCAFE_0001, 4'hF);
        chk("t3_bvalid", 32'(axi_bvalid), 32'd1);
        @(negedge clk);
        chk("t3_no_grant_in_resp", {30'h0, axi_awready, axi_arready}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t3_second_rd", {30'h0, axi_awready, axi_arready}, 32'h1);
        next_cycle();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0; axi_bready = 1'b0;
        next_cycle();
        chk("t3_rvalid", 32'(axi_rvalid), 32'd1);
        chk("t3_rdata", axi_rdata, model_read(32'h10));
        axi_rready = 1'b1;
        next_cycle();
        axi_rready = 1'b0;
        axi_read(32'h20, 0);

        // AW without W is not eligible; acceptance happens only with both.
        axi_awaddr = 32'h28; axi_wdata = 32'h5A5A_A5A5; axi_wstrb = 4'hF; axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_aw_only", {30'h0, axi_awready, axi_wready}, 32'h0);
            next_cycle();
        end
        axi_wvalid = 1'b1;
        @(negedge clk);
        chk("t4_both", {30'h0, axi_awready, axi_wready}, 32'h3);
        next_cycle();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        model_write(32'h28, 32'h5A5A_A5A5, 4'hF);
        chk("t4_bvalid", 32'(axi_bvalid), 32'd1);
        axi_bready = 1'b1;
        next_cycle();
        axi_bready = 1'b0;
        axi_read(32'h28, 0);

        // Response held under back-pressure; no new grant while it is pending.
        exp_d = model_read(32'h10);
        axi_araddr = 32'h10; axi_arvalid = 1'b1;
        wait_grant(1'b1, "t5_rd_grant");
        axi_arvalid = 1'b0;
        next_cycle();
        axi_awaddr = 32'h30; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_rvalid_hold", 32'(axi_rvalid), 32'd1);
            chk("t5_rdata_hold", axi_rdata, exp_d);
            chk("t5_no_grant", {30'h0, axi_awready, axi_arready}, 32'h0);
            next_cycle();
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0; axi_rready = 1'b1;
        next_cycle();
        axi_rready = 1'b0;
        chk("t5_rvalid_drop", 32'(axi_rvalid), 32'd0);

        // Reset in the middle of a read aborts it and restores write priority.
        axi_araddr = 32'h20; axi_arvalid = 1'b1;
        wait_grant(1'b1, "t5r_rd_grant");
        axi_arvalid = 1'b0;
        reset = 1'b1;
        next_cycle();
        chk("t5r_rvalid", 32'(axi_rvalid), 32'd0);
        chk("t5r_rdata", axi_rdata, 32'h0);
        reset = 1'b0;
        axi_awaddr = 32'h24; axi_wdata = 32'h0BAD_F00D; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        @(negedge clk);
        chk("t5r_idle_wr_first", {30'h0, axi_awready, axi_arready}, 32'h2);
        next_cycle();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        model_write(32'h24, 32'h0BAD_F00D, 4'hF);
        chk("t5r_bvalid", 32'(axi_bvalid), 32'd1);
        axi_bready = 1'b1;
        next_cycle();
        axi_bready = 1'b0;
        axi_read(32'h24, 1);

        // Out-of-range accesses never reach the RAM.
        if (SLV_EN) begin
            en_before = en_count;
            axi_read(32'h0000_1000, 1);
            axi_write(32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 0);
            axi_read(32'h0001_0010, 0);
            chk("t6_no_bram_en", 32'(en_count - en_before), 32'd0);
        end

        // Randomized traffic, including aliased upper address bits.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0, 9'h0,
                 5'($urandom_range(0, 31)), 2'($urandom)};
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
